mips32_sum_engine: RTL and testbench

Parametrised hardware accelerator for the mips32 series-sum workload: computes Σi or Σi² for i = 1..N in one accumulation per clock, replacing the software add/addi/slt/bneqz loop. It sits beside the mips32 core as a start/done slave. The core or a bench latches N and a mode, pulses `start`, and reads `result` when `done` pulses. It generalises the fixed 32-bit software loop to configurable width, adds an inclusive-N definition, a squares mode and overflow reporting.

---
 rtl/mips32_sum_engine.sv | 149 ++++++++++++++
 tb/tb_mips32_sum_engine.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mips32_sum_engine.sv
// Series-sum accelerator: accumulates sum(i) or sum(i^2) for i = 1..N, one term per clock.
// Build option: define MIPS32_SUM_SQ_EN to include the squares mode (sq register and adder).
module mips32_sum_engine #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] i_q, i_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] sq_next;
    logic             sq_carry;
    logic [WIDTH:0]   acc_sum;

`ifdef MIPS32_SUM_SQ_EN
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] sq_q, sq_d;
    logic [WIDTH:0]   odd;
    logic [WIDTH:0]   sq_sum;

    // Consecutive squares differ by 2i-1, so sq tracks i^2 with a single adder.
    assign odd      = {i_q, 1'b0} - {{WIDTH{1'b0}}, 1'b1};
    assign sq_sum   = {1'b0, sq_q} + odd;
    assign sq_next  = sq_sum[WIDTH-1:0];
    assign term     = mode_q ? sq_next : i_q;
    assign sq_carry = mode_q & sq_sum[WIDTH];
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign sq_next     = '0;
    assign term        = i_q;
    assign sq_carry    = 1'b0;
`endif

    assign acc_sum = {1'b0, acc_q} + {1'b0, term};

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        acc_d    = acc_q;
        i_d      = i_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef MIPS32_SUM_SQ_EN
        mode_d   = mode_q;
        sq_d     = sq_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d    = n;
                    acc_d  = '0;
                    i_d    = {{(WIDTH-1){1'b0}}, 1'b1};
                    ovf_d  = 1'b0;
                    busy_d = 1'b1;
`ifdef MIPS32_SUM_SQ_EN
                    mode_d = mode;
                    sq_d   = '0;
`endif
                    if (n == '0) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = '0;
                    end else begin
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                acc_d = acc_sum[WIDTH-1:0];
                i_d   = i_q + 1'b1;
                ovf_d = ovf_q | acc_sum[WIDTH] | sq_carry;
`ifdef MIPS32_SUM_SQ_EN
                sq_d  = sq_next;
`endif
                // Compare before increment so n = 2^WIDTH-1 terminates before i wraps.
                if (i_q == n_q) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = acc_sum[WIDTH-1:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            acc_q    <= '0;
            i_q      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MIPS32_SUM_SQ_EN
            mode_q   <= 1'b0;
            sq_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            acc_q    <= acc_d;
            i_q      <= i_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MIPS32_SUM_SQ_EN
            mode_q   <= mode_d;
            sq_q     <= sq_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_mips32_sum_engine.sv
// Directed scoreboard bench for mips32_sum_engine: a 32-bit and an 8-bit instance share clock and reset.
module tb_mips32_sum_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start32 = 1'b0, start8 = 1'b0;
    logic [31:0] n32 = '0;
    logic [7:0]  n8 = '0;
    logic        mode32 = 1'b0, mode8 = 1'b0;
    logic        busy32, done32, ovf32, busy8, done8, ovf8;
    logic [31:0] result32;
    logic [7:0]  result8;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mips32_sum_engine #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .n(n32), .mode(mode32),
        .busy(busy32), .done(done32), .result(result32), .overflow(ovf32)
    );

    mips32_sum_engine #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .n(n8), .mode(mode8),
        .busy(busy8), .done(done8), .result(result8), .overflow(ovf8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One run on the selected instance; optionally re-pulses start (n=3) mid-run on the 32-bit one.
    task automatic run(input bit sel, input logic [31:0] nv, input bit md,
                       input logic [31:0] er, input bit eo, input int repulse);
        exp_t e;
        int   cnt;
        int   busy_cnt;
        bit   got;
        e.res = er; e.ovf = eo; e.lat = int'(nv) + 1;
        sb.push_back(e);
        @(negedge clk);
        if (sel) begin start8 = 1'b1; n8 = nv[7:0]; mode8 = md; end
        else     begin start32 = 1'b1; n32 = nv; mode32 = md; end
        @(negedge clk);
        start8 = 1'b0; start32 = 1'b0;
        cnt = 1; busy_cnt = 0; got = 1'b0;
        while (cnt <= 300) begin
            if (sel ? busy8 : busy32) busy_cnt++;
            got = sel ? done8 : done32;
            if (got) break;
            if (!sel && cnt == repulse) begin start32 = 1'b1; n32 = 32'd3; end
            else start32 = 1'b0;
            @(negedge clk);
            cnt++;
        end
        start32 = 1'b0;
        e = sb.pop_front();
        $display("[TB] run sel=%0d n=%0d mode=%0d -> done=%0d lat=%0d result=%0d ovf=%0d",
                 sel, nv, md, got, cnt, sel ? {24'd0, result8} : result32, sel ? ovf8 : ovf32);
        check("done_seen", {31'd0, got}, 32'd1);
        check("latency", cnt, e.lat);
        check("result", sel ? {24'd0, result8} : result32, e.res);
        check("overflow", {31'd0, sel ? ovf8 : ovf32}, {31'd0, e.ovf});
        check("busy_cycles", busy_cnt, e.lat);
        @(negedge clk);
        check("done_single", {31'd0, sel ? done8 : done32}, 32'd0);
        check("busy_after", {31'd0, sel ? busy8 : busy32}, 32'd0);
    endtask

    initial begin
        int dcount;
        int prev;
        int c;
        logic [31:0] sq_res, sq8_res;
        logic        sq8_ovf;
`ifdef MIPS32_SUM_SQ_EN
        sq_res = 32'd385; sq8_res = 32'd216; sq8_ovf = 1'b1;
`else
        sq_res = 32'd55;  sq8_res = 32'd136; sq8_ovf = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy32}, 32'd0);
        check("rst_done", {31'd0, done32}, 32'd0);
        check("rst_result", result32, 32'd0);
        check("rst_ovf", {31'd0, ovf32}, 32'd0);
        rst = 1'b0;

        run(1'b0, 32'd10, 1'b0, 32'd55, 1'b0, -1);
        run(1'b0, 32'd10, 1'b1, sq_res, 1'b0, -1);
        run(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, -1);
        run(1'b0, 32'd1, 1'b0, 32'd1, 1'b0, -1);
        run(1'b1, 32'd30, 1'b0, 32'd209, 1'b1, -1);
        run(1'b1, 32'd5, 1'b0, 32'd15, 1'b0, -1);
        run(1'b1, 32'd16, 1'b1, sq8_res, sq8_ovf, -1);
        run(1'b0, 32'd10, 1'b0, 32'd55, 1'b0, 3);

        // Async reset mid-run must clear outputs immediately and abandon the run.
        @(negedge clk); start32 = 1'b1; n32 = 32'd10; mode32 = 1'b0;
        @(negedge clk); start32 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy32}, 32'd0);
        check("midrst_result", result32, 32'd0);
        check("midrst_done", {31'd0, done32}, 32'd0);
        rst = 1'b0;
        dcount = 0;
        repeat (15) begin
            @(negedge clk);
            if (done32) dcount++;
        end
        $display("[TB] reset mid-run: done pulses afterwards=%0d", dcount);
        check("midrst_no_done", dcount, 32'd0);
        run(1'b0, 32'd4, 1'b0, 32'd10, 1'b0, -1);

        // Start held high: a new n=2 run every 4 cycles.
        @(negedge clk); start32 = 1'b1; n32 = 32'd2; mode32 = 1'b0;
        dcount = 0; prev = -1; c = 0;
        while (c < 40 && dcount < 3) begin
            @(negedge clk);
            c++;
            if (done32) begin
                $display("[TB] back-to-back done at cycle %0d result=%0d", c, result32);
                check("b2b_result", result32, 32'd3);
                if (prev >= 0) check("b2b_period", c - prev, 32'd4);
                prev = c;
                dcount++;
            end
        end
        start32 = 1'b0;
        check("b2b_count", dcount, 32'd3);
        c = 0;
        while (busy32 && c < 10) begin @(negedge clk); c++; end
        check("b2b_idle", {31'd0, busy32}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
